// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcodes, FSM state encoding
// and default datapath widths.
package exec_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/writeback bundle between register file, decoder and execute stage.
// master: drives issue side (decoder/regfile); slave: the execute unit.
interface alu_exec_unit_if
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              issue_valid;
    logic              issue_ready;
    logic [2:0]        op;
    logic [ADDR_W-1:0] dest_addr;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              flag_zero;
    logic              flag_carry;

    modport master (
        output issue_valid, op, dest_addr, operand_a, operand_b,
        input  issue_ready, wb_en, wb_addr, wb_data, flag_zero, flag_carry
    );

    modport slave (
        input  issue_valid, op, dest_addr, operand_a, operand_b,
        output issue_ready, wb_en, wb_addr, wb_data, flag_zero, flag_carry
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: start loads operands, step advances one
// bit; done is high in the cycle whose edge completes the product.
// Ports: clk, rst, start, step, a, b -> done, product (2*W bits, next value).
// Define MUL_EARLY_TERM_EN to finish as soon as the multiplier runs out.
module seq_multiplier
    import exec_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);
    localparam int CNT_W = $clog2(W);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [2*W-1:0] prod_q, prod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0] prod_step;
    logic           last;

    // product including this cycle's partial term
    assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign product   = prod_step;

`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt_q == CNT_W'(W - 1)) || ((mplier_q >> 1) == '0);
`else
    assign last = (cnt_q == CNT_W'(W - 1));
`endif
    assign done = step && last;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{W{1'b0}}, a};
            mplier_d = b;
            prod_d   = '0;
            cnt_d    = '0;
        end else if (step) begin
            prod_d   = prod_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage behind the 8x16 register file: single-cycle ALU ops and a
// sequential MUL, with a registered writeback to the register file.
// Ports: clk, rst (sync, active high), bus (alu_exec_unit_if.slave).
// MUL_EARLY_TERM_EN (in seq_multiplier) shortens MUL for small operand_b.
module alu_exec_unit
    import exec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic            clk,
    input  logic            rst,
    alu_exec_unit_if.slave  bus
);
    localparam int SH_W = $clog2(DATA_W);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              zero_q, zero_d;
    logic              carry_q, carry_d;

    logic              accept;
    logic              mul_start, mul_step, mul_done;
    logic [2*DATA_W-1:0] mul_prod;

    logic [DATA_W:0]   add_w, sub_w, sll_w, srl_w;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    assign bus.issue_ready = (state_q == ST_IDLE);
    assign accept          = bus.issue_valid && bus.issue_ready;

    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;

    // Extra top bit carries add carry / sub borrow; shifts keep the
    // last bit moved out in the spare bit.
    assign shamt = bus.operand_b[SH_W-1:0];
    assign add_w = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign sub_w = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    assign sll_w = {1'b0, bus.operand_a} << shamt;
    assign srl_w = {bus.operand_a, 1'b0} >> shamt;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        unique case (bus.op)
            OP_ADD: {alu_carry, alu_res} = add_w;
            OP_SUB: {alu_carry, alu_res} = sub_w;
            OP_AND: alu_res = bus.operand_a & bus.operand_b;
            OP_OR:  alu_res = bus.operand_a | bus.operand_b;
            OP_XOR: alu_res = bus.operand_a ^ bus.operand_b;
            OP_SLL: {alu_carry, alu_res} = sll_w;
            OP_SRL: {alu_res, alu_carry} = srl_w;
            OP_MUL: alu_res = '0;
        endcase
    end

    seq_multiplier #(.W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .step    (mul_step),
        .a       (bus.operand_a),
        .b       (bus.operand_b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                if (bus.op == OP_MUL) begin
                    mul_start = 1'b1;
                    dest_d    = bus.dest_addr;
                    state_d   = ST_MUL;
                end else begin
                    wb_en_d   = 1'b1;
                    wb_addr_d = bus.dest_addr;
                    wb_data_d = alu_res;
                    zero_d    = (alu_res == '0);
                    carry_d   = alu_carry;
                end
            end
        end else begin
            mul_step = 1'b1;
            if (mul_done) begin
                wb_en_d   = 1'b1;
                wb_addr_d = dest_q;
                wb_data_d = mul_prod[DATA_W-1:0];
                zero_d    = (mul_prod[DATA_W-1:0] == '0);
                carry_d   = |mul_prod[2*DATA_W-1:DATA_W];
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dest_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed vector table, handshake and reset
// sequences, and random ops against an arithmetic reference model.
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

    alu_exec_unit #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  dest;
        logic [15:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Cycles from accept to the writeback edge for a MUL.
    function automatic int mul_lat(input logic [15:0] b);
`ifdef MUL_EARLY_TERM_EN
        int h = 0;
        for (int i = 0; i < 16; i++)
            if (b[i]) h = i + 1;
        return (h == 0) ? 1 : h;
`else
        return 16;
`endif
    endfunction

    function automatic void model(input logic [2:0] op,
                                  input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] d, output logic c);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned s  = b & 15;
        logic [31:0] r;
        c = 1'b0;
        case (op)
            3'd0: begin r = ua + ub; d = r[15:0]; c = (r > 65535); end
            3'd1: begin d = a - b; c = (ua < ub); end
            3'd2: d = a & b;
            3'd3: d = a | b;
            3'd4: d = a ^ b;
            3'd5: begin
                r = ua << s;
                d = r[15:0];
                c = (s != 0) && r[16];
            end
            3'd6: begin
                r = ua >> s;
                d = r[15:0];
                c = (s != 0) && (((ua >> (s - 1)) & 1) == 1);
            end
            default: begin
                r = ua * ub;
                d = r[15:0];
                c = ((r >> 16) != 0);
            end
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [2:0] d,
                          input logic [15:0] ed, input logic ec,
                          input logic ez, input string nm);
        int lat = (op == 3'd7) ? mul_lat(b) : 0;
        chk({nm, " ready_pre"}, 32'(bus.issue_ready), 1);
        bus.op          = op;
        bus.operand_a   = a;
        bus.operand_b   = b;
        bus.dest_addr   = d;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        bus.operand_a   = 16'hxxxx;
        bus.operand_b   = 16'hxxxx;
        for (int k = 0; k < lat; k++) begin
            chk({nm, " wb_en_early"}, 32'(bus.wb_en), 0);
            chk({nm, " ready_busy"}, 32'(bus.issue_ready), 0);
            tick();
        end
        chk({nm, " wb_en"}, 32'(bus.wb_en), 1);
        chk({nm, " wb_addr"}, 32'(bus.wb_addr), 32'(d));
        chk({nm, " wb_data"}, 32'(bus.wb_data), 32'(ed));
        chk({nm, " carry"}, 32'(bus.flag_carry), 32'(ec));
        chk({nm, " zero"}, 32'(bus.flag_zero), 32'(ez));
        chk({nm, " ready_post"}, 32'(bus.issue_ready), 1);
        tick();
        chk({nm, " wb_en_drop"}, 32'(bus.wb_en), 0);
        chk({nm, " wb_hold"}, 32'(bus.wb_data), 32'(ed));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] md;
        logic        mc;
        logic [2:0]  op;
        logic [15:0] a, b;
        int          pulses;

        vecs.push_back('{3'd0, 16'hFFFF, 16'h0002, 3'd3, 16'h0001, 1'b1, 1'b0});
        vecs.push_back('{3'd1, 16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{3'd1, 16'h0003, 16'h0004, 3'd2, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{3'd2, 16'hF0F0, 16'hFF00, 3'd4, 16'hF000, 1'b0, 1'b0});
        vecs.push_back('{3'd3, 16'h0000, 16'h0000, 3'd6, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{3'd4, 16'h1234, 16'h1234, 3'd7, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{3'd5, 16'h8001, 16'h0001, 3'd0, 16'h0002, 1'b1, 1'b0});
        vecs.push_back('{3'd5, 16'h0001, 16'h000F, 3'd1, 16'h8000, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 16'h0003, 16'h0000, 3'd2, 16'h0003, 1'b0, 1'b0});
        vecs.push_back('{3'd6, 16'h0003, 16'h0001, 3'd3, 16'h0001, 1'b1, 1'b0});
        vecs.push_back('{3'd6, 16'h8001, 16'h001F, 3'd4, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{3'd7, 16'd35,   16'd47,   3'd5, 16'd1645,  1'b0, 1'b0});
        vecs.push_back('{3'd7, 16'd256,  16'd256,  3'd6, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{3'd7, 16'hFFFF, 16'hFFFF, 3'd7, 16'h0001, 1'b1, 1'b0});
        vecs.push_back('{3'd7, 16'h1234, 16'h0000, 3'd1, 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{3'd7, 16'd5,    16'd3,    3'd2, 16'd15,    1'b0, 1'b0});

        bus.issue_valid = 1'b0;
        bus.op          = 3'd0;
        bus.dest_addr   = 3'd0;
        bus.operand_a   = 16'h0;
        bus.operand_b   = 16'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset wb_en", 32'(bus.wb_en), 0);
        chk("reset wb_addr", 32'(bus.wb_addr), 0);
        chk("reset wb_data", 32'(bus.wb_data), 0);
        chk("reset flags", {30'd0, bus.flag_zero, bus.flag_carry}, 0);
        chk("reset ready", 32'(bus.issue_ready), 1);

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
                   vecs[i].exp_data, vecs[i].exp_carry, vecs[i].exp_zero,
                   $sformatf("vec%0d", i));

        // four ADDs back to back
        for (int i = 0; i < 4; i++) begin
            bus.op          = 3'd0;
            bus.operand_a   = 16'(i * 100 + 1);
            bus.operand_b   = 16'(i);
            bus.dest_addr   = 3'(i + 1);
            bus.issue_valid = 1'b1;
            tick();
            model(3'd0, 16'(i * 100 + 1), 16'(i), md, mc);
            chk("b2b wb_en", 32'(bus.wb_en), 1);
            chk("b2b wb_addr", 32'(bus.wb_addr), 32'(i + 1));
            chk("b2b wb_data", 32'(bus.wb_data), 32'(md));
        end
        bus.issue_valid = 1'b0;
        tick();
        chk("b2b drop", 32'(bus.wb_en), 0);

        // valid held through a MUL: the follow-on ADD waits for ready
        bus.op          = 3'd7;
        bus.operand_a   = 16'd7;
        bus.operand_b   = 16'd9;
        bus.dest_addr   = 3'd1;
        bus.issue_valid = 1'b1;
        tick();
        bus.op        = 3'd0;
        bus.operand_a = 16'd1;
        bus.operand_b = 16'd2;
        bus.dest_addr = 3'd2;
        pulses = 0;
        for (int k = 0; k < mul_lat(16'd9); k++) begin
            if (bus.wb_en || bus.issue_ready) pulses++;
            tick();
        end
        chk("hold busy", 32'(pulses), 0);
        chk("hold mul wb_en", 32'(bus.wb_en), 1);
        chk("hold mul data", 32'(bus.wb_data), 63);
        chk("hold mul addr", 32'(bus.wb_addr), 1);
        tick();
        bus.issue_valid = 1'b0;
        chk("hold add wb_en", 32'(bus.wb_en), 1);
        chk("hold add addr", 32'(bus.wb_addr), 2);
        chk("hold add data", 32'(bus.wb_data), 3);
        tick();

        // reset in the middle of a MUL
        run_op(3'd0, 16'hFFFF, 16'h0002, 3'd3, 16'h0001, 1'b1, 1'b0, "pre_rst");
        bus.op          = 3'd7;
        bus.operand_a   = 16'd3;
        bus.operand_b   = 16'hFFFF;
        bus.dest_addr   = 3'd4;
        bus.issue_valid = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst wb_en", 32'(bus.wb_en), 0);
        chk("midrst wb_data", 32'(bus.wb_data), 0);
        chk("midrst flags", {30'd0, bus.flag_zero, bus.flag_carry}, 0);
        chk("midrst ready", 32'(bus.issue_ready), 1);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.wb_en) pulses++;
            tick();
        end
        chk("midrst no_wb", 32'(pulses), 0);

        // random ops against the reference model
        for (int i = 0; i < 80; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (op == 3'd7) b = b >> $urandom_range(0, 16);
            model(op, a, b, md, mc);
            run_op(op, a, b, 3'($urandom_range(0, 7)), md, mc, (md == 16'h0),
                   $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
